// File: rtl/fpu_issue_sequencer.sv
// Issue/collect sequencer for the pipelined half-precision FPU multiplier.
// Tags shadow the FPU pipeline; output stalls freeze both via the clock enable.
module fpu_issue_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             fpu_clk_en,
  output logic [WIDTH-1:0] fpu_dataa,
  output logic [WIDTH-1:0] fpu_datab,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_overflow,
  input  logic             fpu_underflow,
  input  logic             fpu_zero,
  input  logic             fpu_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] done_count,
  output logic             err_sticky
);

  logic               adv;
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] lst;

  // The whole pipe moves only when the output register can take a new word.
  always_comb begin
    adv        = !out_valid || out_ready;
    in_ready   = adv;
    fpu_clk_en = adv;
    fpu_dataa  = in_a;
    fpu_datab  = in_b;
    busy       = (|vld) || out_valid;
  end

  // Valid/last tags mirror the FPU's enabled pipeline stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      lst <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      lst[0] <= in_last;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 4'b0;
      out_last   <= 1'b0;
    end else if (adv) begin
      out_valid  <= vld[LATENCY-1];
      out_result <= fpu_result;
      out_flags  <= {fpu_nan, fpu_overflow, fpu_underflow, fpu_zero};
      out_last   <= lst[LATENCY-1];
    end
  end

  // Counters and the error flag track accepted pairs and delivered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_count <= '0;
      done_count  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (in_valid && in_ready) issue_count <= issue_count + CNT_W'(1);
      if (out_valid && out_ready) begin
        done_count <= done_count + CNT_W'(1);
        if (out_flags[3] || out_flags[2]) err_sticky <= 1'b1;
      end
    end
  end

endmodule
